line_addr_gen: RTL

- Write-side front end of the convolution line buffer in the HDMI filter path.
- Measures the total line period (active plus blanking) from the incoming pixel stream.
- Generates a free-running BRAM address that wraps exactly once per line, so each cascaded single-port RAM stage delays by exactly one line.
- Registers pixel data and packs the DE flag as the stat bit, aligned to the address. Also tracks how many lines since vsync have filled the delay chain.

---
 rtl/line_addr_gen.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/line_addr_gen.sv
// ============================================================================
//  Module      : line_addr_gen
//  Description : Line-period measurement and per-line wrapping BRAM address
//                generator for the write side of a convolution line buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_addr_gen #(
    parameter int ADDR_W  = 12,
    parameter int TAPS    = 5,
    parameter int MIN_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              de_in,
    input  logic              vs_in,
    input  logic [7:0]        data_in,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data_o,
    output logic              stat_o,
    output logic [ADDR_W-1:0] line_len,
    output logic              locked,
    output logic              sync_err,
    output logic              rows_ready
);

    localparam int ROW_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [ADDR_W-1:0] c_cnt_max  = '1;
    localparam logic [ADDR_W-1:0] c_min_len  = ADDR_W'(MIN_LEN);
    localparam logic [ROW_W-1:0]  c_row_full = ROW_W'(TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_de_q;
    logic              r_vs_q;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_len;
    logic              r_err;
    logic              r_locked;
    logic [ROW_W-1:0]  r_row_cnt;
    logic              r_ready;
    logic [7:0]        r_data;
    logic              r_stat;

    logic [ADDR_W-1:0] w_cnt_next;
    logic [ADDR_W-1:0] w_addr_next;
    logic [ADDR_W-1:0] w_len_next;
    logic              w_err_next;
    logic              w_de_rise;
    logic              w_vs_rise;
    logic              w_wrap;

    assign w_de_rise = de_in & ~r_de_q;
    assign w_vs_rise = vs_in & ~r_vs_q;
    assign w_wrap    = (r_addr == (r_len - ADDR_W'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_de_q    <= 1'b0;
            r_vs_q    <= 1'b0;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_err     <= 1'b0;
            r_locked  <= 1'b0;
            r_row_cnt <= '0;
            r_ready   <= 1'b0;
            r_data    <= '0;
            r_stat    <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_de_q   <= de_in;
            r_vs_q   <= vs_in;
            r_cnt    <= w_cnt_next;
            r_addr   <= w_addr_next;
            r_len    <= w_len_next;
            r_err    <= w_err_next;
            r_locked <= (w_next_state == S_RUN);
            r_data   <= data_in;
            r_stat   <= de_in;
            // A line start coinciding with vsync is the first line of the frame.
            if (w_vs_rise) begin
                r_row_cnt <= w_de_rise ? ROW_W'(1) : '0;
            end else if (w_de_rise && (r_row_cnt != c_row_full)) begin
                r_row_cnt <= r_row_cnt + ROW_W'(1);
            end
            r_ready <= r_locked & (r_row_cnt == c_row_full);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_addr_next  = r_addr;
        w_len_next   = r_len;
        w_err_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_addr_next = '0;
                if (w_de_rise) begin
                    w_cnt_next   = ADDR_W'(1);
                    w_next_state = S_MEASURE;
                end
            end
            S_MEASURE: begin
                // A line start wins over a simultaneous counter overflow.
                if (w_de_rise) begin
                    w_cnt_next  = ADDR_W'(1);
                    w_addr_next = '0;
                    if (r_cnt >= c_min_len) begin
                        w_len_next   = r_cnt;
                        w_next_state = S_RUN;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end else if (r_cnt == c_cnt_max) begin
                    w_err_next   = 1'b1;
                    w_addr_next  = '0;
                    w_next_state = S_IDLE;
                end else begin
                    w_cnt_next  = r_cnt + ADDR_W'(1);
                    w_addr_next = r_cnt;
                end
            end
            S_RUN: begin
                w_addr_next = w_wrap ? '0 : (r_addr + ADDR_W'(1));
                if (w_de_rise && !w_wrap) begin
                    w_err_next   = 1'b1;
                    w_addr_next  = '0;
                    w_cnt_next   = ADDR_W'(1);
                    w_next_state = S_MEASURE;
                end
            end
            default: begin
                w_addr_next  = '0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign addr       = r_addr;
    assign data_o     = r_data;
    assign stat_o     = r_stat;
    assign line_len   = r_len;
    assign locked     = r_locked;
    assign sync_err   = r_err;
    assign rows_ready = r_ready;

endmodule

`default_nettype wire
